flipper_ctrl: RTL and testbench

FLIPPER_CTRL -- requirements
Module: flipper_ctrl

---
 rtl/flipper_ctrl.sv | 168 ++++++++++++++++
 tb/tb_flipper_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/flipper_ctrl.sv
// Two-flipper controller: synchronized buttons drive per-flipper IDLE/RISE/HOLD/FALL FSMs stepping on a shared tick.
// Optional build macro FLIPPER_DEBOUNCE_EN adds a DEB_CYCLES stability filter on each synchronized button.

module flipper_lane #(
  parameter int REST_Y = 280,
  parameter int TOP_Y  = 240,
  parameter int STEP   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        pressed,
  output logic [11:0] y,
  output logic        up
);
  typedef enum logic [1:0] {IDLE, RISE, HOLD, FALL} state_t;

  localparam logic [11:0] REST = 12'(REST_Y);
  localparam logic [11:0] TOP  = 12'(TOP_Y);

  state_t      state, state_nx;
  logic [11:0] y_nx, y_dn, y_up;
  logic [31:0] room_dn, room_up;

  // Headroom is measured in 32 bits so a large STEP saturates instead of wrapping.
  assign room_dn = 32'(y) - 32'(TOP_Y);
  assign room_up = 32'(REST_Y) - 32'(y);
  assign y_dn    = (room_dn > 32'(STEP)) ? y - 12'(STEP) : TOP;
  assign y_up    = (room_up > 32'(STEP)) ? y + 12'(STEP) : REST;

  always_comb begin
    state_nx = state;
    y_nx     = y;
    case (state)
      IDLE: begin
        y_nx = REST;
        if (pressed) state_nx = RISE;
      end
      RISE: begin
        if (!pressed) state_nx = FALL;
        else if (tick) begin
          y_nx = y_dn;
          if (y_dn == TOP) state_nx = HOLD;
        end
      end
      HOLD: begin
        y_nx = TOP;
        if (!pressed) state_nx = FALL;
      end
      FALL: begin
        if (pressed) state_nx = RISE;
        else if (tick) begin
          y_nx = y_up;
          if (y_up == REST) state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        y_nx     = REST;
      end
    endcase
  end

  // up follows the next state so it matches the registered state exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      y     <= REST;
      up    <= 1'b0;
    end else begin
      state <= state_nx;
      y     <= y_nx;
      up    <= (state_nx == RISE);
    end
  end
endmodule

module flipper_ctrl #(
  parameter int REST_Y      = 280,
  parameter int TOP_Y       = 240,
  parameter int STEP        = 1,
  parameter int TICK_PERIOD = 250000,
  parameter int DEB_CYCLES  = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_left,
  input  logic        btn_right,
  output logic [11:0] lfmy,
  output logic [11:0] rfmy,
  output logic        lf_up,
  output logic        rf_up
);
  localparam int NF = 2;
  localparam int TW = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;

  if (TOP_Y >= REST_Y || TOP_Y < 0 || REST_Y > 4095 || STEP < 1 ||
      TICK_PERIOD < 1 || DEB_CYCLES < 1) begin : g_bad_params
    $error("flipper_ctrl: illegal parameter set");
  end

  logic [NF-1:0]       sync1, sync2, pressed, up_all;
  logic [NF-1:0][11:0] y_all;
  logic [TW-1:0]       tick_cnt;
  logic                tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {btn_right, btn_left};
      sync2 <= sync1;
    end
  end

  assign tick = (tick_cnt == TW'(TICK_PERIOD - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  for (genvar i = 0; i < NF; i++) begin : g_deb
`ifdef FLIPPER_DEBOUNCE_EN
    localparam int DW = $clog2(DEB_CYCLES + 1);
    logic [DW-1:0] cnt;
    logic          prs;

    // cnt counts consecutive cycles the input disagrees with prs; any agreement restarts it.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt <= '0;
        prs <= 1'b0;
      end else if (sync2[i] == prs) begin
        cnt <= '0;
      end else if (cnt == DW'(DEB_CYCLES - 1)) begin
        cnt <= '0;
        prs <= sync2[i];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
    assign pressed[i] = prs;
`else
    assign pressed[i] = sync2[i];
`endif
  end

  flipper_lane #(
    .REST_Y(REST_Y),
    .TOP_Y (TOP_Y),
    .STEP  (STEP)
  ) u_lane [NF-1:0] (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .pressed(pressed),
    .y      (y_all),
    .up     (up_all)
  );

  assign lfmy  = y_all[0];
  assign rfmy  = y_all[1];
  assign lf_up = up_all[0];
  assign rf_up = up_all[1];
endmodule

// File: tb/tb_flipper_ctrl.sv
// Directed bench for flipper_ctrl: vector table for rise/hold/fall timing plus hand sequences
// for async reset mid-rise and short button pulses.

module tb_flipper_ctrl;
  localparam int TP = 4;
  localparam int DC = 8;
`ifdef FLIPPER_DEBOUNCE_EN
  localparam int LAT = 3 + DC;
`else
  localparam int LAT = 3;
`endif
  localparam int DROP = (LAT - 3) / 4;
  localparam int YB   = 260 - DROP;

  logic        clk = 1'b0, rst = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [11:0] lfmy, rfmy;
  logic        lf_up, rf_up;

  flipper_ctrl #(
    .REST_Y(280), .TOP_Y(240), .STEP(1), .TICK_PERIOD(TP), .DEB_CYCLES(DC)
  ) dut (
    .clk(clk), .rst(rst), .btn_left(btn_left), .btn_right(btn_right),
    .lfmy(lfmy), .rfmy(rfmy), .lf_up(lf_up), .rf_up(rf_up)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit align; bit l; bit r; bit eq;
    int cyc; int ly; int ry; bit lu; bit ru;
  } vec_t;

  vec_t tbl[$];
  int   total = 0, bad = 0, cyc = 0;
  bit   eq_mode = 0, saw_move = 0, saw_up = 0;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      check("lfmy_range", int'(lfmy >= 12'd240 && lfmy <= 12'd280), 1);
      check("rfmy_range", int'(rfmy >= 12'd240 && rfmy <= 12'd280), 1);
      if (eq_mode) begin
        check("lr_eq_y", int'(lfmy), int'(rfmy));
        check("lr_eq_up", int'(lf_up), int'(rf_up));
      end
      if (lfmy != 12'd280) saw_move = 1;
      if (lf_up) saw_up = 1;
    end
  endtask

  function automatic vec_t mk(bit a, bit l, bit r, bit e, int c, int ly, int ry, bit lu, bit ru);
    vec_t v;
    v.align = a; v.l = l; v.r = r; v.eq = e; v.cyc = c;
    v.ly = ly; v.ry = ry; v.lu = lu; v.ru = ru;
    return v;
  endfunction

  initial begin
    // left alone: rise to top, hold, release, fall home
    tbl.push_back(mk(1, 1, 0, 0, LAT, 280, 280, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 4,   279, 280, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 76,  260, 280, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 79,  241, 280, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1,   240, 280, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 20,  240, 280, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, LAT, 240, 280, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1,   241, 280, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 155, 279, 280, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1,   280, 280, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8,   280, 280, 0, 0));
    // release mid-rise near 260
    tbl.push_back(mk(1, 1, 0, 0, LAT, 280, 280, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 80,  260, 280, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, LAT, YB,  280, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1,   YB + 1, 280, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4 * (278 - YB), 279, 280, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4,   280, 280, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8,   280, 280, 0, 0));
    // both buttons together, compared every cycle
    tbl.push_back(mk(1, 1, 1, 1, LAT, 280, 280, 1, 1));
    tbl.push_back(mk(0, 1, 1, 1, 160, 240, 240, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, LAT + 1, 241, 241, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 156, 280, 280, 0, 0));
    // fall interrupted by a new press
    tbl.push_back(mk(1, 1, 0, 0, LAT, 280, 280, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 40,  270, 280, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, LAT, 270 - DROP, 280, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8,   272 - DROP, 280, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, LAT, 273, 280, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2,   272, 280, 1, 0));

    step(3);
    check("rst_lfmy", int'(lfmy), 280);
    check("rst_rfmy", int'(rfmy), 280);
    check("rst_lf_up", int'(lf_up), 0);
    check("rst_rf_up", int'(rf_up), 0);
    rst = 1'b1;
    cyc = 0;
    step(2);
    check("post_rst_lfmy", int'(lfmy), 280);
    check("post_rst_rfmy", int'(rfmy), 280);
    check("post_rst_lf_up", int'(lf_up), 0);
    check("post_rst_rf_up", int'(rf_up), 0);

    foreach (tbl[i]) begin
      if (tbl[i].align) while (cyc % 4 != 1) step(1);
      btn_left  = tbl[i].l;
      btn_right = tbl[i].r;
      eq_mode   = tbl[i].eq;
      step(tbl[i].cyc);
      check($sformatf("v%0d_lfmy", i), int'(lfmy), tbl[i].ly);
      check($sformatf("v%0d_rfmy", i), int'(rfmy), tbl[i].ry);
      check($sformatf("v%0d_lf_up", i), int'(lf_up), int'(tbl[i].lu));
      check($sformatf("v%0d_rf_up", i), int'(rf_up), int'(tbl[i].ru));
    end
    eq_mode = 0;

    // async reset while rising through 255
    step(68);
    check("pre_arst_lfmy", int'(lfmy), 255);
    check("pre_arst_lf_up", int'(lf_up), 1);
    #3 rst = 1'b0;
    #1;
    check("arst_lfmy", int'(lfmy), 280);
    check("arst_lf_up", int'(lf_up), 0);
    check("arst_rfmy", int'(rfmy), 280);
    btn_left = 1'b0;
    step(3);
    rst = 1'b1;
    cyc = 0;
    step(30);
    check("after_arst_lfmy", int'(lfmy), 280);
    check("after_arst_lf_up", int'(lf_up), 0);

    // 3-on/2-off pulses: shorter than the debounce window
    saw_move = 0;
    saw_up   = 0;
    repeat (10) begin
      btn_left = 1'b1;
      step(3);
      btn_left = 1'b0;
      step(2);
    end
`ifdef FLIPPER_DEBOUNCE_EN
    check("pulse_no_move", int'(saw_move), 0);
    check("pulse_no_up", int'(saw_up), 0);
`else
    check("pulse_moved", int'(saw_move), 1);
    check("pulse_up_seen", int'(saw_up), 1);
`endif
    step(200);
    check("settle_lfmy", int'(lfmy), 280);
    check("settle_lf_up", int'(lf_up), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
